stopwatch_controller: RTL

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_if.sv | 38 +++
 rtl/stopwatch_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_if.sv
// Stopwatch control/display bundle: pulse commands in, display and status out.
`timescale 1ns/1ps
interface stopwatch_if;
    localparam int unsigned CNT_W = 6;

    logic             start_stop;
    logic             lap;
    logic             clear;
    logic [CNT_W-1:0] minutes;
    logic [CNT_W-1:0] seconds;
    logic             running;
    logic             lap_active;
    logic             rollover;

    // Command source (panel / testbench) side
    modport master (
        output start_stop,
        output lap,
        output clear,
        input  minutes,
        input  seconds,
        input  running,
        input  lap_active,
        input  rollover
    );

    // Stopwatch core side
    modport slave (
        input  start_stop,
        input  lap,
        input  clear,
        output minutes,
        output seconds,
        output running,
        output lap_active,
        output rollover
    );
endinterface

// File: rtl/stopwatch_controller.sv
// Minutes:seconds stopwatch with run/pause, lap freeze and hourly wrap pulse.
// TICKS_PER_SEC must be at least 2.
`timescale 1ns/1ps
module stopwatch_controller #(
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    stopwatch_if.slave sw
);
    localparam int unsigned PW    = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned CW    = 6;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(59);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUNNING  = 2'd1,
        S_LAP_HOLD = 2'd2,
        S_PAUSED   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [PW-1:0] r_presc;
    logic [CW-1:0] r_min;
    logic [CW-1:0] r_sec;
    logic [CW-1:0] r_disp_min;
    logic [CW-1:0] r_disp_sec;
    logic          r_running;
    logic          r_lap_active;
    logic          r_rollover;

    logic [PW-1:0] w_presc_nxt;
    logic [CW-1:0] w_min_nxt;
    logic [CW-1:0] w_sec_nxt;
    logic [CW-1:0] w_disp_min_nxt;
    logic [CW-1:0] w_disp_sec_nxt;
    logic          w_wrap;
    logic          w_counting;
    logic          w_tick;

    assign w_counting = (r_state == S_RUNNING) || (r_state == S_LAP_HOLD);
    assign w_tick     = w_counting && (r_presc == PRESC_MAX);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: clear beats start_stop beats lap; the loser is dropped
    always_comb begin
        w_state_nxt = r_state;
        if (sw.clear) begin
            w_state_nxt = S_IDLE;
        end else if (sw.start_stop) begin
            case (r_state)
                S_IDLE:     w_state_nxt = S_RUNNING;
                S_RUNNING:  w_state_nxt = S_PAUSED;
                S_LAP_HOLD: w_state_nxt = S_PAUSED;
                S_PAUSED:   w_state_nxt = S_RUNNING;
                default:    w_state_nxt = S_IDLE;
            endcase
        end else if (sw.lap) begin
            case (r_state)
                S_IDLE:     w_state_nxt = S_IDLE;
                S_RUNNING:  w_state_nxt = S_LAP_HOLD;
                S_LAP_HOLD: w_state_nxt = S_RUNNING;
                S_PAUSED:   w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Prescaler, count advance and display selection for the coming edge
    always_comb begin
        w_presc_nxt    = r_presc;
        w_min_nxt      = r_min;
        w_sec_nxt      = r_sec;
        w_wrap         = 1'b0;
        w_disp_min_nxt = r_disp_min;
        w_disp_sec_nxt = r_disp_sec;

        // Entering IDLE (clear or paused lap) zeroes everything and swallows a tick
        if (w_state_nxt == S_IDLE) begin
            w_presc_nxt = '0;
            w_min_nxt   = '0;
            w_sec_nxt   = '0;
        end else if (w_counting) begin
            if (w_tick) begin
                w_presc_nxt = '0;
                if (r_sec == CNT_MAX) begin
                    w_sec_nxt = '0;
                    if (r_min == CNT_MAX) begin
                        w_min_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_min_nxt = r_min + CW'(1);
                    end
                end else begin
                    w_sec_nxt = r_sec + CW'(1);
                end
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end

        // Display tracks the count except while a lap is being held
        if (!((w_state_nxt == S_LAP_HOLD) && (r_state == S_LAP_HOLD))) begin
            w_disp_min_nxt = w_min_nxt;
            w_disp_sec_nxt = w_sec_nxt;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc      <= '0;
            r_min        <= '0;
            r_sec        <= '0;
            r_disp_min   <= '0;
            r_disp_sec   <= '0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_rollover   <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_min        <= w_min_nxt;
            r_sec        <= w_sec_nxt;
            r_disp_min   <= w_disp_min_nxt;
            r_disp_sec   <= w_disp_sec_nxt;
            r_running    <= (w_state_nxt == S_RUNNING) || (w_state_nxt == S_LAP_HOLD);
            r_lap_active <= (w_state_nxt == S_LAP_HOLD);
            r_rollover   <= w_wrap;
        end
    end

    assign sw.minutes    = r_disp_min;
    assign sw.seconds    = r_disp_sec;
    assign sw.running    = r_running;
    assign sw.lap_active = r_lap_active;
    assign sw.rollover   = r_rollover;
endmodule
